// File: rtl/bus_pkg.sv
// Shared encodings for the split-capable two-master bus arbiter.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT1 = 2'b01,
    GRANT2 = 2'b10,
    RESUME = 2'b11
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    M1   = 2'b01,
    M2   = 2'b10
  } owner_e;

endpackage : bus_pkg

// File: rtl/split_arbiter_if.sv
// Request/grant/split handshake bundle between the masters/slave and the arbiter.
interface split_arbiter_if;
  logic breq1;
  logic breq2;
  logic ssplit;
  logic sresume;
  logic bgrant1;
  logic bgrant2;
  logic msel;
  logic msplit1;
  logic msplit2;
  logic split_grant;

  modport slave (
    input  breq1, breq2, ssplit, sresume,
    output bgrant1, bgrant2, msel, msplit1, msplit2, split_grant
  );

  modport master (
    output breq1, breq2, ssplit, sresume,
    input  bgrant1, bgrant2, msel, msplit1, msplit2, split_grant
  );
endinterface : split_arbiter_if

// File: rtl/split_tracker.sv
// Holds the single outstanding split: its owner, per-master split flags and resume_pending.
module split_tracker
  import bus_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   split_set,
  input  owner_e split_who,
  input  logic   sresume,
  input  logic   resume_start,
  input  logic   resume_done,
  output owner_e owner,
  output logic   msplit1,
  output logic   msplit2,
  output logic   resume_pending
);

  owner_e owner_q, owner_d;
  logic   msplit1_q, msplit1_d;
  logic   msplit2_q, msplit2_d;
  logic   pending_q, pending_d;

  // Owner stays valid through RESUME; the msplit flags drop as soon as the resume grant starts.
  always_comb begin
    owner_d   = owner_q;
    msplit1_d = msplit1_q;
    msplit2_d = msplit2_q;
    pending_d = pending_q;
    if (split_set) begin
      owner_d   = split_who;
      msplit1_d = (split_who == M1);
      msplit2_d = (split_who == M2);
      pending_d = sresume;
    end else if (sresume && (msplit1_q || msplit2_q)) begin
      pending_d = 1'b1;
    end
    if (resume_start) begin
      msplit1_d = 1'b0;
      msplit2_d = 1'b0;
      pending_d = 1'b0;
    end
    if (resume_done) begin
      owner_d = NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= NONE;
      msplit1_q <= 1'b0;
      msplit2_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      msplit1_q <= msplit1_d;
      msplit2_q <= msplit2_d;
      pending_q <= pending_d;
    end
  end

  assign owner          = owner_q;
  assign msplit1        = msplit1_q;
  assign msplit2        = msplit2_q;
  assign resume_pending = pending_q;

endmodule : split_tracker

// File: rtl/split_arbiter.sv
// Two-master bus arbiter with fixed priority and single-outstanding split/resume support.
module split_arbiter
  import bus_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  split_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       bgrant1_q, bgrant1_d;
  logic       bgrant2_q, bgrant2_d;
  logic       msel_q, msel_d;
  logic       split_grant_q, split_grant_d;

  owner_e trk_owner;
  logic   trk_msplit1, trk_msplit2, trk_pending;
  logic   outstanding;
  logic   split_c, sresume_c;
  owner_e split_who;
  logic   excl1, excl2;
  logic   owner_breq;
  logic   arb_point;
  logic   resume_start, resume_done;

  assign outstanding = trk_msplit1 || trk_msplit2;
  assign sresume_c   = SPLIT_EN && bus.sresume;
  assign split_c     = SPLIT_EN && bus.ssplit && !outstanding &&
                       ((state_q == GRANT1) || (state_q == GRANT2));
  assign split_who   = (state_q == GRANT1) ? M1 : M2;
  // The master being split this edge is already excluded from the same-edge arbitration.
  assign excl1       = trk_msplit1 || (split_c && (state_q == GRANT1));
  assign excl2       = trk_msplit2 || (split_c && (state_q == GRANT2));
  assign owner_breq  = (trk_owner == M1) ? bus.breq1 : bus.breq2;

  split_tracker u_split_tracker (
    .clk            (clk),
    .rst            (rst),
    .split_set      (split_c),
    .split_who      (split_who),
    .sresume        (sresume_c),
    .resume_start   (resume_start),
    .resume_done    (resume_done),
    .owner          (trk_owner),
    .msplit1        (trk_msplit1),
    .msplit2        (trk_msplit2),
    .resume_pending (trk_pending)
  );

  always_comb begin
    state_d       = state_q;
    msel_d        = msel_q;
    arb_point     = 1'b0;
    resume_start  = 1'b0;
    resume_done   = 1'b0;
    unique case (state_q)
      IDLE:    arb_point = 1'b1;
      GRANT1:  arb_point = !bus.breq1 || split_c;
      GRANT2:  arb_point = !bus.breq2 || split_c;
      RESUME: begin
        arb_point   = !owner_breq;
        resume_done = !owner_breq;
      end
      default: arb_point = 1'b1;
    endcase
    // Priority: pending resume, then master 1, then master 2.
    if (arb_point) begin
      if (trk_pending && !split_c) begin
        state_d      = RESUME;
        resume_start = 1'b1;
      end else if (bus.breq1 && !excl1) begin
        state_d = GRANT1;
      end else if (bus.breq2 && !excl2) begin
        state_d = GRANT2;
      end else begin
        state_d = IDLE;
      end
    end
    bgrant1_d     = (state_d == GRANT1) || ((state_d == RESUME) && (trk_owner == M1));
    bgrant2_d     = (state_d == GRANT2) || ((state_d == RESUME) && (trk_owner == M2));
    split_grant_d = (state_d == RESUME);
    if (bgrant1_d) begin
      msel_d = 1'b0;
    end else if (bgrant2_d) begin
      msel_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bgrant1_q     <= 1'b0;
      bgrant2_q     <= 1'b0;
      msel_q        <= 1'b0;
      split_grant_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bgrant1_q     <= bgrant1_d;
      bgrant2_q     <= bgrant2_d;
      msel_q        <= msel_d;
      split_grant_q <= split_grant_d;
    end
  end

  assign bus.bgrant1     = bgrant1_q;
  assign bus.bgrant2     = bgrant2_q;
  assign bus.msel        = msel_q;
  assign bus.msplit1     = trk_msplit1;
  assign bus.msplit2     = trk_msplit2;
  assign bus.split_grant = split_grant_q;

endmodule : split_arbiter

// File: tb/tb_split_arbiter.sv
// Directed vector bench for split_arbiter (split enabled and split disabled instances).
module tb_split_arbiter;

  // in  = {rst, breq1, breq2, ssplit, sresume}
  // exp = {bgrant1, bgrant2, msel, msplit1, msplit2, split_grant}
  typedef struct packed {
    logic [4:0] in;
    logic [5:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  split_arbiter_if bus_a ();
  split_arbiter_if bus_b ();

  split_arbiter #(.SPLIT_EN(1'b1)) u_dut_en (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  split_arbiter #(.SPLIT_EN(1'b0)) u_dut_dis (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  function automatic logic [5:0] obs_a();
    return {bus_a.bgrant1, bus_a.bgrant2, bus_a.msel,
            bus_a.msplit1, bus_a.msplit2, bus_a.split_grant};
  endfunction

  function automatic logic [5:0] obs_b();
    return {bus_b.bgrant1, bus_b.bgrant2, bus_b.msel,
            bus_b.msplit1, bus_b.msplit2, bus_b.split_grant};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (g1 g2 msel ms1 ms2 sg)", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] in, input logic [5:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step_b(input string name, input logic [4:0] in, input logic [5:0] exp);
    {rst, bus_b.breq1, bus_b.breq2, bus_b.ssplit, bus_b.sresume} = in;
    @(posedge clk);
    #1;
    check(name, obs_b(), exp);
  endtask

  initial begin
    {bus_a.breq1, bus_a.breq2, bus_a.ssplit, bus_a.sresume} = 4'b0000;
    {bus_b.breq1, bus_b.breq2, bus_b.ssplit, bus_b.sresume} = 4'b0000;

    // reset and simultaneous requests, handover with no idle cycle
    add(5'b10000, 6'b000000);
    add(5'b00000, 6'b000000);
    add(5'b01100, 6'b100000);
    add(5'b01100, 6'b100000);
    add(5'b00100, 6'b011000);
    add(5'b00000, 6'b001000);
    // split of M1 hands the bus to M2 at the same edge, then resume to M1
    add(5'b01000, 6'b100000);
    add(5'b01100, 6'b100000);
    add(5'b01110, 6'b011100);
    add(5'b01100, 6'b011100);
    add(5'b01000, 6'b001100);
    add(5'b01000, 6'b001100);
    add(5'b01000, 6'b001100);
    add(5'b01001, 6'b001100);
    add(5'b01000, 6'b100001);
    add(5'b01000, 6'b100001);
    add(5'b00000, 6'b000000);
    // resume taken at M2 release ahead of M1's plain request
    add(5'b01000, 6'b100000);
    add(5'b01110, 6'b011100);
    add(5'b01101, 6'b011100);
    add(5'b01100, 6'b011100);
    add(5'b01000, 6'b100001);
    add(5'b00100, 6'b011000);
    // split and resume in the same cycle on M2
    add(5'b00111, 6'b001010);
    add(5'b00100, 6'b011001);
    add(5'b00000, 6'b001000);
    // second split while one is outstanding is ignored
    add(5'b01000, 6'b100000);
    add(5'b01010, 6'b000100);
    add(5'b01100, 6'b011100);
    add(5'b01110, 6'b011100);
    add(5'b01100, 6'b011100);
    add(5'b01000, 6'b001100);
    add(5'b01001, 6'b001100);
    add(5'b00000, 6'b100001);
    add(5'b00000, 6'b000000);
    // split beats owner release; reset drops split and pending resume
    add(5'b00100, 6'b011000);
    add(5'b00010, 6'b001010);
    add(5'b00101, 6'b001010);
    add(5'b10100, 6'b000000);
    add(5'b00000, 6'b000000);
    add(5'b00000, 6'b000000);
    add(5'b00100, 6'b011000);
    add(5'b00000, 6'b001000);

    for (int i = 0; i < vecs.size(); i++) begin
      {rst, bus_a.breq1, bus_a.breq2, bus_a.ssplit, bus_a.sresume} = vecs[i].in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs_a(), vecs[i].exp);
    end

    // split handling disabled: ssplit/sresume have no effect
    step_b("dis_rst",     5'b10000, 6'b000000);
    step_b("dis_g1",      5'b01000, 6'b100000);
    step_b("dis_ssplit",  5'b01110, 6'b100000);
    step_b("dis_hold",    5'b01100, 6'b100000);
    step_b("dis_sresume", 5'b01101, 6'b100000);
    step_b("dis_handoff", 5'b00100, 6'b011000);
    step_b("dis_idle",    5'b00000, 6'b001000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_split_arbiter
